// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller: opcode values,
// ALUOp / ALUSrcB / PCSrc encodings and the controller state enum.
// The TRAP state exists only when MAIN_CTRL_ILLEGAL_TRAP_EN is defined.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // funct value presented to the ALU whenever it is not doing an R-type op
  localparam logic [5:0] FUNCT_ADD = 6'b100000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
`else
    S_JUMP   = 4'd11
`endif
  } state_t;

endpackage

// File: rtl/main_control_fsm.sv
// Multi-cycle MIPS main controller. Sequences fetch/decode/execute/memory/
// writeback and drives the datapath selects, write enables and ALUOp/funct.
// Build option: MAIN_CTRL_ILLEGAL_TRAP_EN makes unknown opcodes park in a TRAP
// state with illegal=1 until reset; otherwise they retire as a NOP.
//
// Memory handshake: mem_req is held high in FETCH, MEMRD and MEMWR until the
// cycle in which mem_ready is sampled high; that cycle completes the access
// and the FSM leaves the state on the following edge. mem_ready in any other
// state is ignored.
module main_control_fsm
  import mips_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    opcode,
  input  logic [FUNCT_W-1:0] funct_in,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               MemWrite,
  output logic               IorD,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [FUNCT_W-1:0] funct,
  output logic [1:0]         PCSrc,
  output logic               PCWrite,
  output logic               illegal,
  output state_t             fsm_state
);

  state_t state, state_next;

  assign fsm_state = state;

  // State register; reset always lands in FETCH
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state and output decode; every output forced low while reset is high
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_B;
    ALUOp      = ALUOP_ADD;
    PCSrc      = PCSRC_ALU;
    PCWrite    = 1'b0;
    illegal    = 1'b0;
    funct      = FUNCT_W'(FUNCT_ADD);

    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        if (opcode == OP_LW || opcode == OP_SW) state_next = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_next = S_EXEC;
        else if (opcode == OP_BEQ)              state_next = S_BRANCH;
        else if (opcode == OP_ADDI)             state_next = S_ADDIEX;
        else if (opcode == OP_J)                state_next = S_JUMP;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        else                                    state_next = S_TRAP;
`else
        else                                    state_next = S_FETCH;
`endif
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_RTYPE;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_SUB;
        PCSrc      = PCSRC_ALUOUT;
        PCWrite    = zero;
        state_next = S_FETCH;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = PCSRC_JUMP;
        PCWrite    = 1'b1;
        state_next = S_FETCH;
      end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
`endif
      default: state_next = S_FETCH;
    endcase

    // funct follows the instruction only while the ALU is told to decode it
    if (ALUOp == ALUOP_RTYPE) funct = funct_in;

    if (reset) begin
      mem_req  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      RegWrite = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'b00;
      ALUOp    = 2'b00;
      PCSrc    = 2'b00;
      PCWrite  = 1'b0;
      illegal  = 1'b0;
      funct    = '0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm: per-cycle expected output words are derived
// from each instruction's phase list and queued; a negedge monitor compares.
module tb_main_control_fsm;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct_in = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCWrite, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic [5:0] funct;
  state_t     fsm_state;

  logic [21:0] exp_q[$];
  string       name_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  localparam logic [5:0] F = 6'b100000;

  main_control_fsm #(.OP_W(6), .FUNCT_W(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct_in(funct_in),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .funct(funct), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .illegal(illegal), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Expected output word: {mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg,
  // RegWrite, ALUSrcA, ALUSrcB, ALUOp, funct, PCSrc, PCWrite, illegal}
  function automatic logic [21:0] ov(input logic mr, mw, iord, irw, rdst, m2r,
                                     rw, sa, input logic [1:0] sb, aop,
                                     input logic [5:0] fn, input logic [1:0] pcs,
                                     input logic pcw, ill);
    return {mr, mw, iord, irw, rdst, m2r, rw, sa, sb, aop, fn, pcs, pcw, ill};
  endfunction

  // One clock of stimulus plus the response expected during that clock
  task automatic cyc(input logic rst, input logic rdy, input logic z,
                     input logic [21:0] e, input string nm);
    reset     = rst;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_ADDI || op == OP_J;
  endfunction

  task automatic reset_cycle();
    cyc(1'b1, rb(), rb(), 22'd0, "reset");
  endtask

  // Reference: an instruction is fetch, decode, then its class's phases.
  // A memory phase stalls for 'wait' cycles then completes on mem_ready.
  // abort_rd=1 replaces the lw read completion with a reset cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int fw, input int mw,
                           input bit abort_rd);
    opcode   = op;
    funct_in = fn;
    for (int i = 0; i < fw; i++)
      cyc(0, 0, rb(), ov(1,0,0,0,0,0,0,0,2'b01,2'b00,F,2'b00,0,0), "fetch_wait");
    cyc(0, 1, rb(), ov(1,0,0,1,0,0,0,0,2'b01,2'b00,F,2'b00,1,0), "fetch_done");
    cyc(0, rb(), rb(), ov(0,0,0,0,0,0,0,0,2'b11,2'b00,F,2'b00,0,0), "decode");
    if (op == OP_LW || op == OP_SW) begin
      cyc(0, rb(), rb(), ov(0,0,0,0,0,0,0,1,2'b10,2'b00,F,2'b00,0,0), "memadr");
      if (op == OP_LW) begin
        for (int i = 0; i < mw; i++)
          cyc(0, 0, rb(), ov(1,0,1,0,0,0,0,0,2'b00,2'b00,F,2'b00,0,0), "memrd_wait");
        if (abort_rd) begin
          reset_cycle();
        end else begin
          cyc(0, 1, rb(), ov(1,0,1,0,0,0,0,0,2'b00,2'b00,F,2'b00,0,0), "memrd_done");
          cyc(0, rb(), rb(), ov(0,0,0,0,0,1,1,0,2'b00,2'b00,F,2'b00,0,0), "memwb");
        end
      end else begin
        for (int i = 0; i < mw; i++)
          cyc(0, 0, rb(), ov(1,1,1,0,0,0,0,0,2'b00,2'b00,F,2'b00,0,0), "memwr_wait");
        cyc(0, 1, rb(), ov(1,1,1,0,0,0,0,0,2'b00,2'b00,F,2'b00,0,0), "memwr_done");
      end
    end else if (op == OP_RTYPE) begin
      cyc(0, rb(), rb(), ov(0,0,0,0,0,0,0,1,2'b00,2'b10,fn,2'b00,0,0), "exec");
      cyc(0, rb(), rb(), ov(0,0,0,0,1,0,1,0,2'b00,2'b00,F,2'b00,0,0), "aluwb");
    end else if (op == OP_BEQ) begin
      cyc(0, rb(), z, ov(0,0,0,0,0,0,0,1,2'b00,2'b01,F,2'b01,z,0), "branch");
    end else if (op == OP_ADDI) begin
      cyc(0, rb(), rb(), ov(0,0,0,0,0,0,0,1,2'b10,2'b00,F,2'b00,0,0), "addiex");
      cyc(0, rb(), rb(), ov(0,0,0,0,0,0,1,0,2'b00,2'b00,F,2'b00,0,0), "addiwb");
    end else if (op == OP_J) begin
      cyc(0, rb(), rb(), ov(0,0,0,0,0,0,0,0,2'b00,2'b00,F,2'b10,1,0), "jump");
    end else begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 3; i++)
        cyc(0, rb(), rb(), ov(0,0,0,0,0,0,0,0,2'b00,2'b00,F,2'b00,0,1), "trap");
      reset_cycle();
`endif
    end
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  always @(negedge clk) begin
    logic [21:0] act, e;
    string nm;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg, RegWrite,
             ALUSrcA, ALUSrcB, ALUOp, funct, PCSrc, PCWrite, illegal};
      vectors++;
      if (act !== e) begin
        miscompares++;
        $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, e, $time);
      end
    end
  end

  // Directed cases, then randomized instruction stream
  initial begin
    logic [5:0] op;
    logic [5:0] legal_ops[6];
    legal_ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

    @(posedge clk);
    #1;
    reset_cycle();
    vectors++;
    if (fsm_state !== S_FETCH) begin
      miscompares++;
      $display("FAIL reset_state: got %0d expected %0d", fsm_state, S_FETCH);
    end

    run_instr(OP_LW,    6'd0,       0, 1, 1, 0);
    run_instr(OP_RTYPE, 6'b100000,  0, 0, 0, 0);
    run_instr(OP_BEQ,   6'd0,       1, 0, 0, 0);
    run_instr(OP_BEQ,   6'd0,       0, 0, 0, 0);
    run_instr(OP_SW,    6'd0,       0, 0, 5, 0);
    run_instr(OP_ADDI,  6'd0,       0, 2, 0, 0);
    run_instr(OP_J,     6'd0,       0, 0, 0, 0);
    run_instr(OP_LW,    6'd0,       0, 0, 3, 1);
    reset_cycle();
    run_instr(6'b111111, 6'b100010, 0, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      run_instr(op, 6'($urandom), rb(), $urandom_range(0, 3),
                $urandom_range(0, 3), ($urandom_range(0, 9) == 0) && op == OP_LW);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
